// File: rtl/iommu_ddr_win_ctrl.sv
// DDR window offset controller: APB-programmed pending offset, applied to the remap
// bridge only after the AR/AW channels are quiesced and all outstanding bursts drain.
module iommu_ddr_win_ctrl #(
   parameter int unsigned OST_W      = 7,
   parameter logic [31:0] RST_OFFSET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [11:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        awvalid,
   input  logic        awready,
   input  logic        arvalid,
   input  logic        arready,
   input  logic        bvalid,
   input  logic        bready,
   input  logic        rvalid,
   input  logic        rready,
   input  logic        rlast,
   output logic        aw_block,
   output logic        ar_block,
   output logic [31:0] offset
);
   // state  | meaning
   // IDLE   | offset stable, APB may update pending offset and request APPLY
   // DRAIN  | closing AR/AW at handshake boundaries, waiting for counters to reach 0
   // COMMIT | pending offset copied to active, blocks released
   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

   localparam logic [OST_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [31:0]      offset_q, offset_d, pend_q, pend_d;
   logic [OST_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic             aw_block_q, aw_block_d, ar_block_q, ar_block_d;
   logic             wr_ovf_q, wr_ovf_d, rd_ovf_q, rd_ovf_d;

   logic [9:0]       word;
   logic             busy, apb_acc, apb_err, wr_ok, clr_sel;
   logic             wr_evt_ovf, rd_evt_ovf;
   logic [31:0]      status;
   logic             unused_addr_lsb;

   // Returns {ovf, next}; simultaneous inc/dec cancel, overflow/underflow hold the value.
   function automatic logic [OST_W:0] cnt_next(input logic [OST_W-1:0] cnt,
                                               input logic inc, input logic dec);
      logic [OST_W-1:0] n;
      logic             ovf;
      n   = cnt;
      ovf = 1'b0;
      if (inc && !dec) begin
         if (cnt == CNT_MAX) ovf = 1'b1;
         else                n   = cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt == '0) ovf = 1'b1;
         else           n   = cnt - 1'b1;
      end
      return {ovf, n};
   endfunction

   assign unused_addr_lsb = ^paddr[1:0];

   always_comb begin
      word    = paddr[11:2];
      busy    = (state_q != IDLE);
      apb_acc = psel & penable;
      apb_err = (word > 10'd4)
              | (pwrite & ((word == 10'd2) | (word == 10'd3)))
              | (pwrite & busy & ((word == 10'd0) | (word == 10'd1)));
      wr_ok   = apb_acc & pwrite & ~apb_err;
      clr_sel = wr_ok & (word == 10'd4);
   end

   always_comb begin
      status                = '0;
      status[0]             = busy;
      status[1]             = wr_ovf_q;
      status[2]             = rd_ovf_q;
      status[8 +: OST_W]    = rd_cnt_q;
      status[16 +: OST_W]   = wr_cnt_q;
      prdata = '0;
      if (psel && !pwrite) begin
         case (word)
            10'd0:   prdata = pend_q;
            10'd2:   prdata = status;
            10'd3:   prdata = offset_q;
            default: prdata = '0;
         endcase
      end
   end

   assign pready   = 1'b1;
   assign pslverr  = apb_acc & apb_err;
   assign aw_block = aw_block_q;
   assign ar_block = ar_block_q;
   assign offset   = offset_q;

   // Counters only see handshakes the bridge actually lets through.
   always_comb begin
      {wr_evt_ovf, wr_cnt_d} = cnt_next(wr_cnt_q, awvalid & awready & ~aw_block_q, bvalid & bready);
      {rd_evt_ovf, rd_cnt_d} = cnt_next(rd_cnt_q, arvalid & arready & ~ar_block_q,
                                        rvalid & rready & rlast);
      wr_ovf_d = (wr_ovf_q & ~(clr_sel & pwdata[1])) | wr_evt_ovf;
      rd_ovf_d = (rd_ovf_q & ~(clr_sel & pwdata[2])) | rd_evt_ovf;
   end

   always_comb begin
      state_d    = state_q;
      offset_d   = offset_q;
      pend_d     = pend_q;
      aw_block_d = aw_block_q;
      ar_block_d = ar_block_q;
      if (wr_ok && word == 10'd0) pend_d = pwdata;
      case (state_q)
         IDLE: begin
            if (wr_ok && word == 10'd1 && pwdata[0]) state_d = DRAIN;
         end
         DRAIN: begin
            // Block only when no valid is pending, so an asserted valid is never withdrawn.
            if (!awvalid || awready) aw_block_d = 1'b1;
            if (!arvalid || arready) ar_block_d = 1'b1;
            if (aw_block_q && ar_block_q && wr_cnt_q == '0 && rd_cnt_q == '0) state_d = COMMIT;
         end
         COMMIT: begin
            offset_d   = pend_q;
            aw_block_d = 1'b0;
            ar_block_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         offset_q   <= RST_OFFSET;
         pend_q     <= RST_OFFSET;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         aw_block_q <= 1'b0;
         ar_block_q <= 1'b0;
         wr_ovf_q   <= 1'b0;
         rd_ovf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         pend_q     <= pend_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         aw_block_q <= aw_block_d;
         ar_block_q <= ar_block_d;
         wr_ovf_q   <= wr_ovf_d;
         rd_ovf_q   <= rd_ovf_d;
      end
   end
endmodule

// File: doc/iommu_ddr_win_ctrl.md
Name: iommu_ddr_win_ctrl

Overview:
APB-programmable controller for the DDR window offset consumed by the DDR address-remap bridge.
- Holds a pending and an active offset and drives the active one onto the bridge's `offset` input.
- Tracks outstanding read and write transactions through the bridge.
- Applies a new offset only after quiescing the AR/AW channels and draining all in-flight traffic, so no burst is ever split across two offsets.

Parameters:
- OST_W, 7, width of the outstanding-transaction counters (max count 2^OST_W-1).
- RST_OFFSET, 32'h0000_0000, value of the active and pending offset after reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  12  APB byte address; bits [1:0] ignored.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data, valid in the access phase.
- pready  output  1  tied 1 (zero wait).
- pslverr  output  1  APB error.
- awvalid, awready, arvalid, arready  input  1 each  upstream-side AXI address handshake signals.
- bvalid, bready, rvalid, rready, rlast  input  1 each  AXI response handshake signals.
- aw_block  output  1  registered; top level gates `awvalid` and `awready` with ~aw_block.
- ar_block  output  1  registered; same gating for the AR channel.
- offset  output  32  active offset to the remap bridge.

Behaviour:
- Reset values: `offset`=RST_OFFSET; pending offset=RST_OFFSET; both counters=0; `aw_block`=0; `ar_block`=0; state=IDLE; sticky ovf bits=0; `prdata`=0 when not selected; `pslverr`=0.
- Register map (byte offsets):
  - 0x00 OFFSET_PEND (RW).
  - 0x04 CTRL: bit0 APPLY, write-1, reads 0.
  - 0x08 STATUS (RO): bit0 busy (state!=IDLE); bit1 wr_ovf; bit2 rd_ovf; [14:8] rd_cnt; [22:16] wr_cnt.
  - 0x0C OFFSET_ACT (RO): mirrors `offset`.
  - 0x10 STATUS_CLR: write-1 clears the ovf bits.
- APB:
  - Access completes when psel&penable; pready=1 always.
  - `pslverr`=1 on an unmapped address, a write to an RO register, or any write to 0x00/0x04 while busy. An erroring write has no effect.
- Counters use effective (gated) handshakes:
  - wr_cnt: +1 on awvalid&awready&~aw_block; -1 on bvalid&bready. Both in the same cycle → unchanged.
  - rd_cnt: +1 on arvalid&arready&~ar_block; -1 on rvalid&rready&rlast. Both in the same cycle → unchanged.
  - An increment at max saturates and sets the sticky ovf bit.
  - A decrement at 0 holds at 0 and sets the ovf bit.
- FSM:
  - IDLE: an APB write of CTRL.APPLY=1 → DRAIN next cycle.
  - DRAIN, AW side: `aw_block` sets at the clock edge ending a cycle in which awvalid=0, or in which an AW handshake completes. This ensures the downstream never sees a valid withdrawn. `ar_block` sets the same way on the AR channel. Once set, a block stays set until COMMIT.
  - DRAIN → COMMIT: when `aw_block`&`ar_block`&wr_cnt==0&rd_cnt==0 are all true in the same cycle.
  - COMMIT (1 cycle): `offset` ← pending offset; `aw_block` and `ar_block` clear at the end of COMMIT; → IDLE.
  - Minimum APPLY-to-new-offset latency with an idle bus: 3 cycles (DRAIN, block registered, COMMIT).
- Response channels (B/R) are never gated; draining always progresses.
- `rst` asserted in any state: all state returns to reset values on the next edge, including dropping the blocks. The traffic source is also under reset.
- No timeout: DRAIN waits indefinitely.

Test Plan:
- Idle apply: reset; write 0x00=0x1000_0000, write 0x04=1 → `offset`=0x1000_0000 exactly 3 cycles after the APPLY access; `aw_block`/`ar_block` pulse high 2 cycles; STATUS.busy reads 0 afterward.
- Drain with traffic: issue 2 ARs (len 3) and 1 AW, then APPLY; hold rready=0 for 10 cycles → `offset` unchanged and STATUS shows rd_cnt=2, wr_cnt=1; new ARs/AWs are blocked (no counter increment); complete all responses → COMMIT occurs 1 cycle after the last rlast/b handshake.
- Valid-held safety: awvalid=1, awready=0 when APPLY is written → `aw_block` stays 0 until awready=1 completes the handshake, then sets; wr_cnt=1 until its B arrives.
- APB errors: write 0x00 while busy → pslverr=1 and pending offset unchanged; read 0x20 → pslverr=1; write 0x0C → pslverr=1.
- Counter boundaries: simultaneous AR handshake and last-R handshake at rd_cnt=1 → rd_cnt stays 1; B handshake at wr_cnt=0 → wr_cnt=0 and wr_ovf=1; write 0x10=0x6 clears wr_ovf.
- Reset mid-drain: APPLY with wr_cnt=3, then assert `rst` one cycle → `offset`=RST_OFFSET, blocks=0, counters=0, busy=0.
